// File: rtl/canbac_pkg.sv
// Shared definitions for the sequential float32 n-th root unit:
// float32 constants and field layout, plus the controller state encoding.
package canbac_pkg;

  localparam int          BIAS = 127;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;
  localparam logic [31:0] PINF = 32'h7F80_0000;
  localparam logic [31:0] NINF = 32'hFF80_0000;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] mant;
  } f32_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_POW,
    S_CMP,
    S_PACK,
    S_DONE
  } state_t;

endpackage

// File: rtl/nhan_fixed.sv
// Unsigned fixed-point multiply with INT_W integer and FRAC_W fraction bits;
// the product is truncated toward zero back to FRAC_W fraction bits.
module nhan_fixed #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 30
) (
  input  logic [INT_W+FRAC_W-1:0] a_i,
  input  logic [INT_W+FRAC_W-1:0] b_i,
  output logic [INT_W+FRAC_W-1:0] p_o
);

  localparam int W = INT_W + FRAC_W;

  logic [2*W-1:0] full;

  assign full = a_i * b_i;
  // Callers keep operands small enough that the integer part never overflows.
  assign p_o  = W'(full >> FRAC_W);

endmodule

// File: rtl/canbac_n_seq.sv
// Sequential float32 n-th root: decodes y and n, extracts the root mantissa one
// bit at a time by raising trial values to the ni-th power on a shared multiplier.
module canbac_n_seq
  import canbac_pkg::*;
#(
  parameter int MAX_N  = 16,
  parameter int FRAC_W = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] y,
  input  logic [31:0] n,
  output logic        busy,
  output logic        done,
  output logic [31:0] ketqua,
  output logic        loi
);

  localparam int W     = MAX_N + FRAC_W;
  localparam int NI_W  = $clog2(MAX_N + 1);
  localparam int PC_W  = $clog2(MAX_N);
  localparam int NUM_W = 8 + NI_W + 1;
  localparam int SH    = FRAC_W - 23;

  state_t          state_q, state_d;
  f32_t            y_q, y_d;
  f32_t            n_q, n_d;
  logic [NI_W-1:0] ni_q, ni_d;
  logic [7:0]      expo_q, expo_d;
  logic [W-1:0]    t_q, t_d;
  logic [W-1:0]    p_q, p_d;
  logic [23:0]     root_q, root_d;
  logic [4:0]      bit_q, bit_d;
  logic [PC_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]     res_q, res_d;
  logic            res_loi_q, res_loi_d;
  logic [31:0]     ketqua_q, ketqua_d;
  logic            loi_q, loi_d;
  logic            done_q, done_d;

  // ---------------- decode of the latched operands ----------------
  logic [23:0]      n_full;
  logic [4:0]       n_k;
  logic [46:0]      n_shl;
  logic             n_valid;
  logic [NI_W-1:0]  ni_dec, div_n;
  logic             y_zero, y_inf, y_nan;
  logic [NUM_W-1:0] num, quo, rem;
  logic [7:0]       expo_dec;
  logic [NI_W-1:0]  r_dec;
  logic [W-1:0]     t_dec;
  logic             spec_hit, spec_loi;
  logic [31:0]      spec_res;

  assign n_full  = {1'b1, n_q.mant};
  assign n_k     = 5'(n_q.exp - 8'd127);
  // Integer part lands in [46:23], any fractional remainder in [22:0].
  assign n_shl   = {23'b0, n_full} << n_k;
  assign n_valid = !n_q.sign && (n_q.exp >= 8'd127) && (n_q.exp <= 8'd150)
                   && (n_shl[22:0] == 23'b0) && (n_shl[46:23] <= 24'(MAX_N));
  assign ni_dec  = NI_W'(n_shl[46:23]);
  assign div_n   = (ni_dec == '0) ? NI_W'(1) : ni_dec;

  assign y_zero = (y_q.exp == 8'd0);
  assign y_inf  = (y_q.exp == 8'hFF) && (y_q.mant == 23'b0);
  assign y_nan  = (y_q.exp == 8'hFF) && (y_q.mant != 23'b0);

  // Offsetting e by 128*ni keeps the dividend positive, so plain unsigned
  // division yields floor(e/ni)+128 and a remainder already in [0, ni).
  assign num      = NUM_W'(y_q.exp) + (NUM_W'(div_n) << 7) - NUM_W'(BIAS);
  assign quo      = num / NUM_W'(div_n);
  assign rem      = num % NUM_W'(div_n);
  assign expo_dec = 8'(quo - NUM_W'(1));
  assign r_dec    = NI_W'(rem);
  assign t_dec    = W'({1'b1, y_q.mant}) << (SH + int'(r_dec));

  always_comb begin
    spec_hit = 1'b1;
    spec_loi = 1'b0;
    spec_res = QNAN;
    if (!n_valid || y_nan) begin
      spec_loi = 1'b1;
    end else if (y_q.sign && !y_zero && !ni_dec[0]) begin
      spec_loi = 1'b1;
    end else if (y_zero) begin
      spec_res = {y_q.sign, 31'b0};
    end else if (y_inf) begin
      spec_res = y_q.sign ? NINF : PINF;
    end else if (ni_dec == NI_W'(1)) begin
      spec_res = y_q;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // ---------------- root extraction datapath ----------------
  logic [23:0]  trial, root_nx, trial_nx;
  logic [W-1:0] c_fix, prod;

  assign trial    = root_q | (24'd1 << bit_q);
  assign c_fix    = W'(trial) << SH;
  assign root_nx  = (p_q <= t_q) ? trial : root_q;
  assign trial_nx = root_nx | (24'd1 << (bit_q - 5'd1));

  nhan_fixed #(
    .INT_W (MAX_N),
    .FRAC_W(FRAC_W)
  ) u_nhan (
    .a_i(p_q),
    .b_i(c_fix),
    .p_o(prod)
  );

  // ---------------- controller ----------------
  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    n_d       = n_q;
    ni_d      = ni_q;
    expo_d    = expo_q;
    t_d       = t_q;
    p_d       = p_q;
    root_d    = root_q;
    bit_d     = bit_q;
    pcnt_d    = pcnt_q;
    res_d     = res_q;
    res_loi_d = res_loi_q;
    ketqua_d  = ketqua_q;
    loi_d     = loi_q;
    done_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          y_d     = y;
          n_d     = n;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        ni_d      = ni_dec;
        expo_d    = expo_dec;
        t_d       = t_dec;
        root_d    = 24'h80_0000;
        bit_d     = 5'd22;
        pcnt_d    = PC_W'(ni_dec - NI_W'(2));
        p_d       = W'(24'hC0_0000) << SH;
        res_d     = spec_res;
        res_loi_d = spec_loi;
        state_d   = spec_hit ? S_DONE : S_POW;
      end
      S_POW: begin
        p_d = prod;
        if (pcnt_q == '0) state_d = S_CMP;
        else              pcnt_d  = pcnt_q - PC_W'(1);
      end
      S_CMP: begin
        root_d = root_nx;
        if (bit_q == 5'd0) begin
          state_d = S_PACK;
        end else begin
          bit_d   = bit_q - 5'd1;
          pcnt_d  = PC_W'(ni_q - NI_W'(2));
          p_d     = W'(trial_nx) << SH;
          state_d = S_POW;
        end
      end
      S_PACK: begin
        res_d     = {y_q.sign, expo_q, root_q[22:0]};
        res_loi_d = 1'b0;
        state_d   = S_DONE;
      end
      S_DONE: begin
        ketqua_d = res_q;
        loi_d    = res_loi_q;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      y_q       <= '0;
      n_q       <= '0;
      ni_q      <= '0;
      expo_q    <= '0;
      t_q       <= '0;
      p_q       <= '0;
      root_q    <= '0;
      bit_q     <= '0;
      pcnt_q    <= '0;
      res_q     <= '0;
      res_loi_q <= 1'b0;
      ketqua_q  <= '0;
      loi_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      n_q       <= n_d;
      ni_q      <= ni_d;
      expo_q    <= expo_d;
      t_q       <= t_d;
      p_q       <= p_d;
      root_q    <= root_d;
      bit_q     <= bit_d;
      pcnt_q    <= pcnt_d;
      res_q     <= res_d;
      res_loi_q <= res_loi_d;
      ketqua_q  <= ketqua_d;
      loi_q     <= loi_d;
      done_q    <= done_d;
    end
  end

  // busy stays up through the done pulse so a new request lands the cycle after.
  assign busy   = (state_q != S_IDLE) || done_q;
  assign done   = done_q;
  assign ketqua = ketqua_q;
  assign loi    = loi_q;

endmodule

// File: tb/tb_canbac_n_seq.sv
// Bench for canbac_n_seq: directed table, hand-written abort/ignore sequences,
// and random operands checked against a real/integer reference model.
module tb_canbac_n_seq;

  localparam int MAX_N = 16;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] y, n;
  logic        busy, done, loi;
  logic [31:0] ketqua;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  canbac_n_seq #(.MAX_N(MAX_N), .FRAC_W(30)) dut (
    .clk(clk), .rst(rst), .start(start), .y(y), .n(n),
    .busy(busy), .done(done), .ketqua(ketqua), .loi(loi)
  );

  typedef struct {
    logic [31:0] y;
    logic [31:0] n;
    logic [31:0] k;
    logic        l;
    int          lat;
    string       name;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Issues one request once the unit is free; lat counts clock edges from
  // the acceptance edge to the edge that raises done.
  task automatic run_op(input logic [31:0] yv, input logic [31:0] nv,
                        output logic [31:0] k, output logic l, output int lat);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    start = 1'b1; y = yv; n = nv;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (!done && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    k = ketqua;
    l = loi;
    $display("op y=%h n=%h -> ketqua=%h loi=%0d latency=%0d", yv, nv, k, l, lat);
  endtask

  function automatic logic [31:0] int_to_f32(input int v);
    int k;
    logic [31:0] m;
    k = 0;
    while ((v >> (k + 1)) != 0) k++;
    m = 32'(v) << (23 - k);
    return {1'b0, 8'(127 + k), m[22:0]};
  endfunction

  // Reference: n decoded as a real number, exponent split with signed floor
  // division, root bits found by direct trial powering at wide precision.
  function automatic void model(input logic [31:0] yv, input logic [31:0] nv,
                                output logic [31:0] k, output logic l, output int lat);
    real nr;
    int en, ey, ni, e, q, r;
    bit nvalid;
    logic [95:0] tt, pp, cc;
    logic [23:0] rr, cm;
    en = int'(nv[30:23]);
    ey = int'(yv[30:23]);
    nvalid = 0;
    ni = 0;
    if (en != 255 && en != 0 && !nv[31]) begin
      nr = real'({1'b1, nv[22:0]}) / 8388608.0;
      for (int i = 127; i < en; i++) nr = nr * 2.0;
      for (int i = en; i < 127; i++) nr = nr / 2.0;
      if (nr >= 1.0 && nr <= real'(MAX_N) && nr == real'($rtoi(nr))) begin
        nvalid = 1;
        ni = $rtoi(nr);
      end
    end
    l = 1'b0;
    lat = 2;
    if (!nvalid || (ey == 255 && yv[22:0] != 0) || (yv[31] && ey != 0 && ni % 2 == 0)) begin
      k = 32'h7FC00000;
      l = 1'b1;
    end else if (ey == 0) begin
      k = {yv[31], 31'b0};
    end else if (ey == 255) begin
      k = {yv[31], 8'hFF, 23'b0};
    end else if (ni == 1) begin
      k = yv;
    end else begin
      e = ey - 127;
      q = (e >= 0) ? e / ni : -((-e + ni - 1) / ni);
      r = e - q * ni;
      tt = 96'({1'b1, yv[22:0]}) << (7 + r);
      rr = 24'h800000;
      for (int b = 22; b >= 0; b--) begin
        cm = rr | (24'd1 << b);
        cc = 96'(cm) << 7;
        pp = cc;
        for (int i = 1; i < ni; i++) pp = (pp * cc) >> 30;
        if (pp <= tt) rr = cm;
      end
      k = {yv[31], 8'(q + 127), rr[22:0]};
      lat = 3 + 23 * ni;
    end
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl [15];
    logic [31:0] k, ek;
    logic        l, el;
    int          lat, elat, extra, ni;

    rst = 1'b1; start = 1'b0; y = '0; n = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_done", {31'b0, done}, 32'd0);
    check("reset_ketqua", ketqua, 32'd0);
    check("reset_loi", {31'b0, loi}, 32'd0);
    rst = 1'b0;

    tbl[0]  = '{32'h41D80000, 32'h40400000, 32'h40400000, 1'b0, 72,  "cube27"};
    tbl[1]  = '{32'h3E800000, 32'h40000000, 32'h3F000000, 1'b0, 49,  "sqrt_quarter"};
    tbl[2]  = '{32'hC1000000, 32'h40400000, 32'hC0000000, 1'b0, 72,  "cube_neg8"};
    tbl[3]  = '{32'hC0800000, 32'h40000000, 32'h7FC00000, 1'b1, 2,   "sqrt_neg4"};
    tbl[4]  = '{32'h41D80000, 32'h40500000, 32'h7FC00000, 1'b1, 2,   "n_3p25"};
    tbl[5]  = '{32'h00000000, 32'h40400000, 32'h00000000, 1'b0, 2,   "zero"};
    tbl[6]  = '{32'h7F800000, 32'h40800000, 32'h7F800000, 1'b0, 2,   "pinf"};
    tbl[7]  = '{32'h40490FDB, 32'h3F800000, 32'h40490FDB, 1'b0, 2,   "n_one"};
    tbl[8]  = '{32'h00400000, 32'h40000000, 32'h00000000, 1'b0, 2,   "subnormal"};
    tbl[9]  = '{32'h7FC00001, 32'h40000000, 32'h7FC00000, 1'b1, 2,   "y_nan"};
    tbl[10] = '{32'h41D80000, 32'h41880000, 32'h7FC00000, 1'b1, 2,   "n_17"};
    tbl[11] = '{32'h47800000, 32'h41800000, 32'h40000000, 1'b0, 371, "n_16"};
    tbl[12] = '{32'h41D80000, 32'hC0400000, 32'h7FC00000, 1'b1, 2,   "n_neg3"};
    tbl[13] = '{32'hFF800000, 32'h40400000, 32'hFF800000, 1'b0, 2,   "ninf_odd"};
    tbl[14] = '{32'h80000000, 32'h40000000, 32'h80000000, 1'b0, 2,   "neg_zero"};

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].y, tbl[i].n, k, l, lat);
      check($sformatf("%s_ketqua", tbl[i].name), k, tbl[i].k);
      check($sformatf("%s_loi", tbl[i].name), {31'b0, l}, {31'b0, tbl[i].l});
      check($sformatf("%s_latency", tbl[i].name), 32'(lat), 32'(tbl[i].lat));
    end

    // A second start while busy must be dropped, not queued.
    @(negedge clk);
    while (busy) @(negedge clk);
    start = 1'b1; y = 32'h41D80000; n = 32'h40400000;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 1000) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 5) begin start = 1'b1; y = 32'h3E800000; n = 32'h40000000; end
      if (lat == 6) start = 1'b0;
    end
    $display("op busy-restart y=41d80000 n=40400000 -> ketqua=%h latency=%0d", ketqua, lat);
    check("ignore_ketqua", ketqua, 32'h40400000);
    check("ignore_latency", 32'(lat), 32'd72);
    extra = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done) extra++;
    end
    check("ignore_no_second_done", 32'(extra), 32'd0);

    // Reset in the middle of the power loop aborts without a done.
    @(negedge clk);
    start = 1'b1; y = 32'h41D80000; n = 32'h40400000;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    $display("op abort by rst -> ketqua=%h busy=%0d done=%0d loi=%0d", ketqua, busy, done, loi);
    check("abort_ketqua", ketqua, 32'd0);
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_done", {31'b0, done}, 32'd0);
    check("abort_loi", {31'b0, loi}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (done || busy) extra++;
    end
    check("abort_stays_idle", 32'(extra), 32'd0);
    run_op(32'h3E800000, 32'h40000000, k, l, lat);
    check("after_abort_ketqua", k, 32'h3F000000);
    check("after_abort_latency", 32'(lat), 32'd49);

    // Random normal operands across the whole root-order range.
    for (int i = 0; i < 40; i++) begin
      logic [31:0] yr, nr32;
      ni = int'($urandom_range(2, MAX_N));
      nr32 = int_to_f32(ni);
      yr = {1'($urandom_range(0, 1)), 8'($urandom_range(1, 254)), 23'($urandom)};
      model(yr, nr32, ek, el, elat);
      run_op(yr, nr32, k, l, lat);
      check($sformatf("rand%0d_ketqua", i), k, ek);
      check($sformatf("rand%0d_loi", i), {31'b0, l}, {31'b0, el});
      check($sformatf("rand%0d_latency", i), 32'(lat), 32'(elat));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
